// File: rtl/nibble_scan_pkg.sv
// ============================================================================
// nibble_scan_pkg : shared widths and FSM state type for the nibble scanner
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

package nibble_scan_pkg;
   localparam int LANES  = 256;
   localparam int NIB_W  = 4;
   localparam int SEL_W  = 8;
   localparam int CNT_W  = 9;
   localparam int WORD_W = LANES * NIB_W;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;
endpackage

`default_nettype wire

// File: rtl/nibble_mux256.sv
// ============================================================================
// nibble_mux256 : combinational 256-to-1 selector of 4-bit lanes
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module nibble_mux256
   import nibble_scan_pkg::*;
(
   input  logic [WORD_W-1:0] data,
   input  logic [SEL_W-1:0]  sel,
   output logic [NIB_W-1:0]  nibble
);

   // Lane offset is sel*4; the concatenation gives an exact 10-bit bit index.
   assign nibble = data[{sel, 2'b00} +: NIB_W];

endmodule

`default_nettype wire

// File: rtl/nibble_scan_ctrl.sv
// ============================================================================
// nibble_scan_ctrl : streams lanes of a 1024-bit word one nibble per beat
// Optional macro NIBBLE_SCAN_PREFETCH_EN : accept next word on the final beat
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module nibble_scan_ctrl
   import nibble_scan_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic [SEL_W-1:0]  in_first,
   input  logic [CNT_W-1:0]  in_count,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [NIB_W-1:0]  out_nibble,
   output logic [SEL_W-1:0]  out_sel,
   output logic              out_last,
   output logic              busy
);

   state_e            state_q, state_d;
   logic [WORD_W-1:0] data_q,  data_d;
   logic [SEL_W-1:0]  sel_q,   sel_d;
   logic [CNT_W-1:0]  rem_q,   rem_d;

   logic accept;
   logic beat;

   assign accept = in_valid & in_ready;
   assign beat   = out_valid & out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         data_q  <= '0;
         sel_q   <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         rem_q   <= rem_d;
      end
   end

   // in_ready is gated by flush, so an accept never coincides with a flush.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sel_d   = sel_q;
      rem_d   = rem_q;
      if (flush) begin
         state_d = S_IDLE;
      end else if (accept) begin
         data_d  = in_data;
         sel_d   = in_first;
         rem_d   = in_count;
         state_d = (in_count == '0) ? S_IDLE : S_RUN;
      end else if (beat) begin
         if (out_last) begin
            state_d = S_IDLE;
         end else begin
            sel_d = sel_q + SEL_W'(1);
            rem_d = rem_q - CNT_W'(1);
         end
      end
   end

   always_comb begin
      out_valid = (state_q == S_RUN);
      busy      = (state_q == S_RUN);
      out_sel   = sel_q;
      out_last  = (state_q == S_RUN) && (rem_q == CNT_W'(1));
`ifdef NIBBLE_SCAN_PREFETCH_EN
      if (state_q == S_IDLE)
         in_ready = !reset && !flush;
      else
         in_ready = out_valid && out_ready && out_last && !flush && !reset;
`else
      in_ready = (state_q == S_IDLE) && !reset && !flush;
`endif
   end

   nibble_mux256 u_mux (
      .data   (data_q),
      .sel    (sel_q),
      .nibble (out_nibble)
   );

endmodule

`default_nettype wire
